// File: rtl/aead_serial_host_pkg.sv
// Shared types and constants for the AEAD serial host.
package aead_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        CAPTURE,
        DONE
    } state_t;

    localparam int NONCE_W = 128;
    localparam int TAG_W   = 128;

    // Largest of four widths; sizes the load phase to the longest field.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/aead_serial_host_piso.sv
// Parallel-in, MSB-first serial-out shift register with zero fill.
module aead_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] par_in,
    output logic         ser_out
);

    logic [W-1:0] sr;

    // Capture the field on load, then shift left with zeros entering at the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       sr <= '0;
        else if (load)  sr <= par_in;
        else if (shift) sr <= sr << 1;
    end

    assign ser_out = shift & sr[W-1];

endmodule

// File: rtl/aead_serial_host.sv
// Host-side driver: serialises key/nonce/AD/text into the AEAD core, starts it,
// and deserialises the LSB-first result streams.
module aead_serial_host
    import aead_pkg::*;
#(
    parameter int K       = 128,
    parameter int L       = 40,
    parameter int Y       = 40,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [K-1:0]   key_in,
    input  logic [127:0]   nonce_in,
    input  logic [L-1:0]   ad_in,
    input  logic [Y-1:0]   pt_in,
    input  logic [127:0]   r128_in,
    input  logic [Y-1:0]   rpt_in,
    output logic           aead_rst,
    output logic           key_so,
    output logic           nonce_so,
    output logic           ad_so,
    output logic           pt_so,
    output logic           r128_so,
    output logic           rpt_so,
    output logic           enc_start_so,
    output logic           dec_start_so,
    input  logic           enc_ready_si,
    input  logic           dec_ready_si,
    input  logic           ct_si,
    input  logic           tag_si,
    input  logic           dpt_si,
    input  logic           dtag_si,
    input  logic           auth_si,
    output logic           busy,
    output logic           done,
    output logic           timeout_err,
    output logic           auth_ok,
    output logic [Y-1:0]   text_out,
    output logic [127:0]   tag_out
);

    localparam int N  = max4(K, NONCE_W, L, Y);
    localparam int CW = $clog2(max4(N + 2, TIMEOUT, 0, 0) + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          mode_q;
    logic          accept, loading, ready_sel, text_bit, tag_bit;

    assign accept    = (state == IDLE) && start;
    assign loading   = (state == LOAD);
    assign ready_sel = mode_q ? dec_ready_si : enc_ready_si;
    assign text_bit  = mode_q ? dpt_si : ct_si;
    assign tag_bit   = mode_q ? dtag_si : tag_si;

    aead_piso #(.W(K))       u_key   (.clk(clk), .rst(rst), .load(accept), .shift(loading), .par_in(key_in),   .ser_out(key_so));
    aead_piso #(.W(NONCE_W)) u_nonce (.clk(clk), .rst(rst), .load(accept), .shift(loading), .par_in(nonce_in), .ser_out(nonce_so));
    aead_piso #(.W(L))       u_ad    (.clk(clk), .rst(rst), .load(accept), .shift(loading), .par_in(ad_in),    .ser_out(ad_so));
    aead_piso #(.W(Y))       u_pt    (.clk(clk), .rst(rst), .load(accept), .shift(loading), .par_in(pt_in),    .ser_out(pt_so));
    aead_piso #(.W(NONCE_W)) u_r128  (.clk(clk), .rst(rst), .load(accept), .shift(loading), .par_in(r128_in),  .ser_out(r128_so));
    aead_piso #(.W(Y))       u_rpt   (.clk(clk), .rst(rst), .load(accept), .shift(loading), .par_in(rpt_in),   .ser_out(rpt_so));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state decode and per-state core control outputs.
    always_comb begin
        state_nx     = state;
        aead_rst     = 1'b0;
        enc_start_so = 1'b0;
        dec_start_so = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                aead_rst = 1'b1;
                busy     = 1'b0;
                if (start) state_nx = LOAD;
            end
            LOAD:    if (cnt == CW'(N - 1)) state_nx = SETTLE;
            SETTLE:  if (cnt == CW'(1)) state_nx = RUN;
            RUN: begin
                enc_start_so = 1'b1;
                dec_start_so = mode_q;
                if (ready_sel)                      state_nx = CAPTURE;
                else if (cnt == CW'(TIMEOUT - 1))   state_nx = DONE;
            end
            CAPTURE: if (cnt == CW'(TAG_W)) state_nx = DONE;
            DONE: begin
                aead_rst = 1'b1;
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Phase counter, latched mode, status flags and result deserialisation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            mode_q      <= 1'b0;
            timeout_err <= 1'b0;
            auth_ok     <= 1'b0;
            text_out    <= '0;
            tag_out     <= '0;
        end else begin
            if (state_nx != state || state == IDLE) cnt <= '0;
            else                                    cnt <= cnt + CW'(1);

            if (accept) begin
                mode_q      <= mode;
                timeout_err <= 1'b0;
                auth_ok     <= 1'b0;
            end

            if (state == RUN && !ready_sel && cnt == CW'(TIMEOUT - 1))
                timeout_err <= 1'b1;

            // Capture cycle 0 carries no stream data; bit b arrives on cycle b+1.
            if (state == CAPTURE) begin
                if (cnt == '0) begin
                    if (mode_q) auth_ok <= auth_si;
                end else begin
                    for (int unsigned i = 0; i < TAG_W; i++)
                        if (32'(cnt) == i + 1) tag_out[i] <= tag_bit;
                    for (int unsigned i = 0; i < Y; i++)
                        if (32'(cnt) == i + 1 && i < TAG_W) text_out[i] <= text_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_aead_serial_host.sv
// Directed bench for aead_serial_host using a behavioural core stub.
module tb_aead_serial_host;

    localparam logic [39:0]  CT_PAT   = 40'hA53C960FE1;
    localparam logic [39:0]  DPT_PAT  = 40'h0001020304;
    localparam logic [127:0] TAG_PAT  = 128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
    localparam logic [127:0] DTAG_PAT = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam int           RDY_LAT  = 3;

    localparam logic [127:0] KEY_S   = 128'h80000000_00000000_00000000_00000001;
    localparam logic [127:0] KEY_V   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] R128_S  = 128'hFEDCBA98_76543210_00000000_00000001;
    localparam logic [39:0]  AD_S    = 40'h8000000001;
    localparam logic [39:0]  AD_V    = 40'h0001020304;
    localparam logic [39:0]  RPT_S   = 40'h1F2E3D4C5B;

    logic clk, rst, start, mode;
    logic [127:0] key_in, nonce_in, r128_in, tag_out;
    logic [39:0]  ad_in, pt_in, rpt_in, text_out;
    logic aead_rst, key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so;
    logic enc_start_so, dec_start_so, enc_ready_si, dec_ready_si;
    logic ct_si, tag_si, dpt_si, dtag_si, auth_si;
    logic busy, done, timeout_err, auth_ok;

    int vecs = 0;
    int miss = 0;

    aead_serial_host #(.K(128), .L(40), .Y(40), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .key_in(key_in), .nonce_in(nonce_in), .ad_in(ad_in), .pt_in(pt_in),
        .r128_in(r128_in), .rpt_in(rpt_in), .aead_rst(aead_rst),
        .key_so(key_so), .nonce_so(nonce_so), .ad_so(ad_so), .pt_so(pt_so),
        .r128_so(r128_so), .rpt_so(rpt_so),
        .enc_start_so(enc_start_so), .dec_start_so(dec_start_so),
        .enc_ready_si(enc_ready_si), .dec_ready_si(dec_ready_si),
        .ct_si(ct_si), .tag_si(tag_si), .dpt_si(dpt_si), .dtag_si(dtag_si),
        .auth_si(auth_si), .busy(busy), .done(done), .timeout_err(timeout_err),
        .auth_ok(auth_ok), .text_out(text_out), .tag_out(tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stub: ready RDY_LAT cycles into start, registered LSB-first streams after.
    bit   stub_never = 1'b0;
    logic stub_auth  = 1'b1;
    int   stub_sc, stub_oc;
    always @(posedge clk) begin
        if (aead_rst) begin
            stub_sc <= 0; stub_oc <= -1;
            enc_ready_si <= 1'b0; dec_ready_si <= 1'b0; auth_si <= 1'b0;
            ct_si <= 1'b0; tag_si <= 1'b0; dpt_si <= 1'b0; dtag_si <= 1'b0;
        end else if (stub_oc < 0) begin
            if (enc_start_so) begin
                stub_sc <= stub_sc + 1;
                if (stub_sc == RDY_LAT && !stub_never) begin
                    stub_oc      <= 0;
                    enc_ready_si <= !dec_start_so;
                    dec_ready_si <= dec_start_so;
                end
            end
        end else begin
            stub_oc <= stub_oc + 1;
            if (stub_oc == 1) begin enc_ready_si <= 1'b0; dec_ready_si <= 1'b0; end
            auth_si <= (stub_oc == 0) ? stub_auth : 1'b0;
            if (stub_oc >= 1 && stub_oc <= 128) begin
                tag_si  <= TAG_PAT[stub_oc - 1];
                dtag_si <= DTAG_PAT[stub_oc - 1];
                ct_si   <= (stub_oc <= 40) ? CT_PAT[stub_oc - 1]  : 1'b0;
                dpt_si  <= (stub_oc <= 40) ? DPT_PAT[stub_oc - 1] : 1'b0;
            end else begin
                tag_si <= 1'b0; dtag_si <= 1'b0; ct_si <= 1'b0; dpt_si <= 1'b0;
            end
        end
    end

    // Bit-level monitor of the load stream and activity counters.
    int lc = 0, start_lc = -1, zero_err = 0;
    int done_cnt = 0, run_cyc = 0, dec_cyc = 0;
    logic [127:0] rec_key, rec_nonce, rec_r128;
    logic [39:0]  rec_ad, rec_pt, rec_rpt;
    always @(negedge clk) begin
        if (done)         done_cnt++;
        if (enc_start_so) run_cyc++;
        if (dec_start_so) dec_cyc++;
        if (aead_rst) lc = 0;
        else begin
            if (lc == 0) begin start_lc = -1; zero_err = 0; end
            if (lc < 128) begin
                rec_key[127 - lc]   = key_so;
                rec_nonce[127 - lc] = nonce_so;
                rec_r128[127 - lc]  = r128_so;
            end else if (key_so | nonce_so | r128_so) zero_err++;
            if (lc < 40) begin
                rec_ad[39 - lc]  = ad_so;
                rec_pt[39 - lc]  = pt_so;
                rec_rpt[39 - lc] = rpt_so;
            end else if (ad_so | pt_so | rpt_so) zero_err++;
            if (enc_start_so && start_lc < 0) start_lc = lc;
            lc++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic m, input logic [127:0] k, input logic [127:0] n,
                      input logic [39:0] a, input logic [39:0] p,
                      input logic [127:0] r, input logic [39:0] rp);
        @(negedge clk);
        mode = m; key_in = k; nonce_in = n; ad_in = a; pt_in = p; r128_in = r; rpt_in = rp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        chk(tag, 128'(done), 128'(1'b1));
    endtask

    initial begin
        int d0, r0, q0, n;
        rst = 1'b0; start = 1'b0; mode = 1'b0;
        key_in = '0; nonce_in = '0; ad_in = '0; pt_in = '0; r128_in = '0; rpt_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_aead_rst", 128'(aead_rst), 128'(1'b1));
        chk("rst_status",   128'({busy, done, timeout_err, auth_ok}), 128'(4'b0000));
        chk("rst_serial",   128'({key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so, enc_start_so, dec_start_so}), 128'(8'h00));
        chk("rst_text",     128'(text_out), 128'(40'h0));
        chk("rst_tag",      tag_out, 128'h0);
        rst = 1'b1;

        // Encrypt with serialisation vectors.
        d0 = done_cnt; r0 = run_cyc; q0 = dec_cyc;
        go(1'b0, KEY_S, KEY_V, AD_S, DPT_PAT, R128_S, RPT_S);
        chk("enc_busy", 128'(busy), 128'(1'b1));
        wait_done("enc_done_seen");
        repeat (3) @(negedge clk);
        chk("ser_key",   rec_key, KEY_S);
        chk("ser_nonce", rec_nonce, KEY_V);
        chk("ser_r128",  rec_r128, R128_S);
        chk("ser_ad",    128'(rec_ad), 128'(AD_S));
        chk("ser_pt",    128'(rec_pt), 128'(DPT_PAT));
        chk("ser_rpt",   128'(rec_rpt), 128'(RPT_S));
        chk("ser_zero_fill", 128'(zero_err), 128'd0);
        chk("load_len_start_lc", 128'(start_lc), 128'd130);
        chk("enc_done_once", 128'(done_cnt - d0), 128'd1);
        chk("enc_run_cycles", 128'(run_cyc - r0), 128'd5);
        chk("enc_no_dec_start", 128'(dec_cyc - q0), 128'd0);
        chk("enc_text", 128'(text_out), 128'(CT_PAT));
        chk("enc_tag",  tag_out, TAG_PAT);
        chk("enc_flags", 128'({timeout_err, auth_ok, busy, aead_rst}), 128'(4'b0001));

        // Decrypt, auth pass.
        d0 = done_cnt; q0 = dec_cyc;
        go(1'b1, KEY_V, KEY_V, AD_V, AD_V, R128_S, RPT_S);
        wait_done("dec_done_seen");
        repeat (3) @(negedge clk);
        chk("dec_done_once", 128'(done_cnt - d0), 128'd1);
        chk("dec_start_cycles", 128'(dec_cyc - q0), 128'd5);
        chk("dec_text", 128'(text_out), 128'(DPT_PAT));
        chk("dec_tag",  tag_out, DTAG_PAT);
        chk("dec_auth_ok", 128'(auth_ok), 128'(1'b1));
        chk("dec_timeout", 128'(timeout_err), 128'(1'b0));

        // Timeout: core never ready.
        stub_never = 1'b1;
        d0 = done_cnt; r0 = run_cyc;
        go(1'b0, KEY_V, KEY_V, AD_V, AD_V, R128_S, RPT_S);
        wait_done("to_done_seen");
        chk("to_run_cycles", 128'(run_cyc - r0), 128'd16);
        chk("to_err", 128'(timeout_err), 128'(1'b1));
        repeat (3) @(negedge clk);
        stub_never = 1'b0;
        chk("to_done_once", 128'(done_cnt - d0), 128'd1);
        chk("to_aead_rst_after", 128'(aead_rst), 128'(1'b1));
        chk("to_auth_cleared", 128'(auth_ok), 128'(1'b0));
        chk("to_text_held", 128'(text_out), 128'(DPT_PAT));
        chk("to_tag_held",  tag_out, DTAG_PAT);

        // Encrypt with a start pulse during CAPTURE.
        d0 = done_cnt;
        go(1'b0, KEY_V, KEY_V, AD_V, AD_V, R128_S, RPT_S);
        n = 0;
        while (enc_start_so !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (enc_start_so === 1'b1 && n < 400) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        mode = 1'b1; key_in = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("cap_done_seen");
        repeat (3) @(negedge clk);
        chk("cap_done_once", 128'(done_cnt - d0), 128'd1);
        chk("cap_idle_after", 128'({busy, aead_rst}), 128'(2'b01));
        chk("cap_text", 128'(text_out), 128'(CT_PAT));
        chk("cap_tag",  tag_out, TAG_PAT);
        chk("cap_timeout_cleared", 128'(timeout_err), 128'(1'b0));

        // Reset at load cycle 50.
        go(1'b0, '1, KEY_V, AD_V, AD_V, R128_S, RPT_S);
        repeat (50) @(negedge clk);
        chk("mid_key_so_before", 128'(key_so), 128'(1'b1));
        rst = 1'b0;
        #1;
        chk("mid_aead_rst", 128'(aead_rst), 128'(1'b1));
        chk("mid_status", 128'({busy, done, timeout_err, auth_ok}), 128'(4'b0000));
        chk("mid_serial", 128'({key_so, nonce_so, ad_so, pt_so, r128_so, rpt_so, enc_start_so, dec_start_so}), 128'(8'h00));
        chk("mid_text", 128'(text_out), 128'(40'h0));
        chk("mid_tag",  tag_out, 128'h0);
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_done", 128'(done_cnt - d0), 128'd0);

        // Normal encrypt after the abort.
        d0 = done_cnt;
        go(1'b0, KEY_V, KEY_V, AD_V, AD_V, R128_S, RPT_S);
        wait_done("post_done_seen");
        repeat (3) @(negedge clk);
        chk("post_done_once", 128'(done_cnt - d0), 128'd1);
        chk("post_key", rec_key, KEY_V);
        chk("post_text", 128'(text_out), 128'(CT_PAT));
        chk("post_tag",  tag_out, TAG_PAT);
        chk("post_timeout", 128'(timeout_err), 128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
